// File: rtl/buzzer_decoder.sv
// Recovers the 2-bit beep mode from a buzzer square wave by timing rising-edge periods.
// Optional macro BUZZ_DEC_STATS_EN adds a saturating glitch_cnt output.
`timescale 1ns/1ps

module buzzer_decoder #(
   parameter int HALF_PERIOD = 50000001,
   parameter int CNT_W       = 30
) (
   input  logic       clk,
   input  logic       RST,
   input  logic       buzzer_i,
   output logic [7:0] mode_o,
   output logic       mode_valid,
`ifdef BUZZ_DEC_STATS_EN
   output logic [7:0] glitch_cnt,
`endif
   output logic       mode_chg
);

   typedef enum logic [1:0] {S_SILENT, S_FIRST, S_CONFIRM, S_TRACK} state_t;

   localparam logic [CNT_W-1:0] LIM_1   = CNT_W'(HALF_PERIOD);
   localparam logic [CNT_W-1:0] LIM_3   = CNT_W'(3 * HALF_PERIOD);
   localparam logic [CNT_W-1:0] LIM_6   = CNT_W'(6 * HALF_PERIOD);
   localparam logic [CNT_W-1:0] LIM_12  = CNT_W'(12 * HALF_PERIOD);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state;
   logic [1:0]       sync_ff;
   logic             dly;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       cand;
   logic [1:0]       mode_q;
   logic [1:0]       p_class;
   logic             edge_det;
   logic             timeout;

   assign edge_det = sync_ff[1] & ~dly;
   assign timeout  = (cnt == LIM_12);
   assign mode_o   = {6'b000000, mode_q};

   // cnt holds the period in clk cycles at the moment an edge is seen; class 0 means invalid
   always_comb begin
      p_class = 2'd0;
      if (cnt >= LIM_1 && cnt < LIM_3)
         p_class = 2'd1;
      else if (cnt >= LIM_3 && cnt < LIM_6)
         p_class = 2'd2;
      else if (cnt >= LIM_6 && cnt < LIM_12)
         p_class = 2'd3;
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         sync_ff    <= 2'b00;
         dly        <= 1'b0;
         cnt        <= '0;
         state      <= S_SILENT;
         cand       <= 2'd0;
         mode_q     <= 2'd0;
         mode_valid <= 1'b0;
         mode_chg   <= 1'b0;
      end else begin
         sync_ff  <= {sync_ff[0], buzzer_i};
         dly      <= sync_ff[1];
         mode_chg <= 1'b0;
         if (!timeout)
            cnt <= cnt + CNT_ONE;
         case (state)
            S_SILENT: begin
               if (edge_det) begin
                  cnt   <= CNT_ONE;
                  state <= S_FIRST;
               end else if (timeout) begin
                  mode_valid <= 1'b1;
               end
            end
            S_FIRST: begin
               if (edge_det) begin
                  cnt <= CNT_ONE;
                  if (p_class != 2'd0) begin
                     cand  <= p_class;
                     state <= S_CONFIRM;
                  end
               end else if (timeout) begin
                  mode_q     <= 2'd0;
                  mode_valid <= 1'b1;
                  mode_chg   <= |mode_q;
                  state      <= S_SILENT;
               end
            end
            // invalid periods leave the counter running from the last accepted edge
            S_CONFIRM: begin
               if (edge_det) begin
                  if (p_class != 2'd0) begin
                     cnt <= CNT_ONE;
                     if (p_class == cand) begin
                        mode_q     <= cand;
                        mode_valid <= 1'b1;
                        mode_chg   <= (cand != mode_q);
                        state      <= S_TRACK;
                     end else begin
                        cand <= p_class;
                     end
                  end
               end else if (timeout) begin
                  mode_q     <= 2'd0;
                  mode_valid <= 1'b1;
                  mode_chg   <= |mode_q;
                  state      <= S_SILENT;
               end
            end
            S_TRACK: begin
               if (edge_det) begin
                  if (p_class != 2'd0) begin
                     cnt <= CNT_ONE;
                     if (p_class != mode_q) begin
                        cand  <= p_class;
                        state <= S_CONFIRM;
                     end
                  end
               end else if (timeout) begin
                  mode_q     <= 2'd0;
                  mode_valid <= 1'b1;
                  mode_chg   <= |mode_q;
                  state      <= S_SILENT;
               end
            end
            default: state <= S_SILENT;
         endcase
      end
   end

`ifdef BUZZ_DEC_STATS_EN
   always_ff @(posedge clk or posedge RST) begin
      if (RST)
         glitch_cnt <= 8'd0;
      else if (edge_det && state != S_SILENT && cnt < LIM_1 && glitch_cnt != 8'hFF)
         glitch_cnt <= glitch_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_buzzer_decoder.sv
// Scoreboard bench for buzzer_decoder with HALF_PERIOD=10 (periods 20/40/80 map to modes 1/2/3).
`timescale 1ns/1ps

module tb_buzzer_decoder;

   logic       clk = 1'b0;
   logic       RST = 1'b1;
   logic       buzzer_i = 1'b0;
   logic [7:0] mode_o;
   logic       mode_valid;
   logic       mode_chg;
`ifdef BUZZ_DEC_STATS_EN
   logic [7:0] glitch_cnt;
`endif

   int         check_cnt = 0;
   int         pass_cnt = 0;
   int         cyc = 0;
   int         chg_cyc = 0;
   logic       prev_chg = 1'b0;
   logic [7:0] exp_q[$];

   buzzer_decoder #(.HALF_PERIOD(10), .CNT_W(8)) dut (
      .clk(clk),
      .RST(RST),
      .buzzer_i(buzzer_i),
      .mode_o(mode_o),
      .mode_valid(mode_valid),
`ifdef BUZZ_DEC_STATS_EN
      .glitch_cnt(glitch_cnt),
`endif
      .mode_chg(mode_chg)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every mode_chg pulse must match the next expected mode pushed by a test
   always @(negedge clk) begin
      if (!RST && mode_chg) begin
         chg_cyc = cyc;
         check_cnt++;
         if (exp_q.size() == 0) begin
            $display("[TB] FAIL unexpected_chg: got mode_chg with mode_o=%0d, expected no pulse (cycle %0d)", mode_o, cyc);
         end else begin
            automatic logic [7:0] exp_mode = exp_q.pop_front();
            if (mode_o !== exp_mode)
               $display("[TB] FAIL chg_mode: got %0d expected %0d (cycle %0d)", mode_o, exp_mode, cyc);
            else
               pass_cnt++;
         end
         check_cnt++;
         if (prev_chg)
            $display("[TB] FAIL chg_consecutive: got two adjacent pulses, expected single-cycle pulse");
         else
            pass_cnt++;
      end
      prev_chg = mode_chg;
   end

   task automatic applyStimulus(input int period, input int n);
      for (int i = 0; i < n; i++) begin
         buzzer_i = 1'b1;
         repeat (period / 2) @(negedge clk);
         buzzer_i = 1'b0;
         repeat (period - period / 2) @(negedge clk);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      check_cnt++;
      if (mode_o !== 8'h00) $display("[TB] FAIL reset_mode: got %0d expected 0", mode_o); else pass_cnt++;
      check_cnt++;
      if (mode_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b expected 0", mode_valid); else pass_cnt++;
      check_cnt++;
      if (mode_chg !== 1'b0) $display("[TB] FAIL reset_chg: got %0b expected 0", mode_chg); else pass_cnt++;
`ifdef BUZZ_DEC_STATS_EN
      check_cnt++;
      if (glitch_cnt !== 8'd0) $display("[TB] FAIL reset_glitch: got %0d expected 0", glitch_cnt); else pass_cnt++;
`endif
      RST = 1'b0;
   endtask

   task automatic test_silence;
      repeat (130) @(negedge clk);
      check_cnt++;
      if (mode_valid !== 1'b1) $display("[TB] FAIL silence_valid: got %0b expected 1", mode_valid); else pass_cnt++;
      check_cnt++;
      if (mode_o !== 8'h00) $display("[TB] FAIL silence_mode: got %0d expected 0", mode_o); else pass_cnt++;
   endtask

   task automatic test_mode01;
      exp_q.push_back(8'h01);
      applyStimulus(20, 4);
      check_cnt++;
      if (mode_o !== 8'h01) $display("[TB] FAIL mode01: got %0d expected 1", mode_o); else pass_cnt++;
      check_cnt++;
      if (mode_valid !== 1'b1) $display("[TB] FAIL mode01_valid: got %0b expected 1", mode_valid); else pass_cnt++;
      check_cnt++;
      if (exp_q.size() != 0) $display("[TB] FAIL mode01_pending: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_switch;
      exp_q.push_back(8'h03);
      applyStimulus(80, 2);
      check_cnt++;
      if (mode_o !== 8'h01) $display("[TB] FAIL switch_hold: got %0d expected 1", mode_o); else pass_cnt++;
      check_cnt++;
      if (exp_q.size() != 1) $display("[TB] FAIL switch_early: got %0d pending expected 1", exp_q.size()); else pass_cnt++;
      applyStimulus(80, 1);
      check_cnt++;
      if (mode_o !== 8'h03) $display("[TB] FAIL switch_mode: got %0d expected 3", mode_o); else pass_cnt++;
      check_cnt++;
      if (exp_q.size() != 0) $display("[TB] FAIL switch_pending: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_timeout;
      int t_hi;
      t_hi = cyc;
      exp_q.push_back(8'h00);
      buzzer_i = 1'b1;
      repeat (40) @(negedge clk);
      buzzer_i = 1'b0;
      repeat (100) @(negedge clk);
      check_cnt++;
      if (exp_q.size() != 0) $display("[TB] FAIL timeout_pending: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
      check_cnt++;
      if (chg_cyc != t_hi + 123) $display("[TB] FAIL timeout_cycle: got %0d expected %0d", chg_cyc, t_hi + 123); else pass_cnt++;
      check_cnt++;
      if (mode_o !== 8'h00) $display("[TB] FAIL timeout_mode: got %0d expected 0", mode_o); else pass_cnt++;
      check_cnt++;
      if (mode_valid !== 1'b1) $display("[TB] FAIL timeout_valid: got %0b expected 1", mode_valid); else pass_cnt++;
   endtask

   task automatic test_glitch;
      exp_q.push_back(8'h02);
      applyStimulus(40, 3);
      check_cnt++;
      if (mode_o !== 8'h02) $display("[TB] FAIL glitch_lock: got %0d expected 2", mode_o); else pass_cnt++;
      buzzer_i = 1'b1;
      repeat (20) @(negedge clk);
      buzzer_i = 1'b0;
      repeat (13) @(negedge clk);
      buzzer_i = 1'b1;
      repeat (3) @(negedge clk);
      buzzer_i = 1'b0;
      repeat (4) @(negedge clk);
      applyStimulus(40, 2);
      check_cnt++;
      if (mode_o !== 8'h02) $display("[TB] FAIL glitch_mode: got %0d expected 2", mode_o); else pass_cnt++;
      check_cnt++;
      if (exp_q.size() != 0) $display("[TB] FAIL glitch_pending: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
`ifdef BUZZ_DEC_STATS_EN
      check_cnt++;
      if (glitch_cnt !== 8'd1) $display("[TB] FAIL glitch_cnt: got %0d expected 1", glitch_cnt); else pass_cnt++;
`endif
   endtask

   task automatic test_reset_mid;
      buzzer_i = 1'b1;
      repeat (15) @(negedge clk);
      @(posedge clk);
      #3 RST = 1'b1;
      #1;
      check_cnt++;
      if (mode_o !== 8'h00) $display("[TB] FAIL midrst_mode: got %0d expected 0", mode_o); else pass_cnt++;
      check_cnt++;
      if (mode_valid !== 1'b0) $display("[TB] FAIL midrst_valid: got %0b expected 0", mode_valid); else pass_cnt++;
`ifdef BUZZ_DEC_STATS_EN
      check_cnt++;
      if (glitch_cnt !== 8'd0) $display("[TB] FAIL midrst_glitch: got %0d expected 0", glitch_cnt); else pass_cnt++;
`endif
      buzzer_i = 1'b0;
      repeat (2) @(negedge clk);
      RST = 1'b0;
      exp_q.push_back(8'h01);
      applyStimulus(20, 2);
      check_cnt++;
      if (mode_o !== 8'h00) $display("[TB] FAIL midrst_early_mode: got %0d expected 0", mode_o); else pass_cnt++;
      check_cnt++;
      if (mode_valid !== 1'b0) $display("[TB] FAIL midrst_early_valid: got %0b expected 0", mode_valid); else pass_cnt++;
      applyStimulus(20, 1);
      check_cnt++;
      if (mode_o !== 8'h01) $display("[TB] FAIL midrst_mode01: got %0d expected 1", mode_o); else pass_cnt++;
      check_cnt++;
      if (mode_valid !== 1'b1) $display("[TB] FAIL midrst_valid01: got %0b expected 1", mode_valid); else pass_cnt++;
      check_cnt++;
      if (exp_q.size() != 0) $display("[TB] FAIL midrst_pending: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_alternate;
      for (int i = 0; i < 6; i++)
         applyStimulus((i % 2 == 1) ? 20 : 40, 1);
      check_cnt++;
      if (mode_o !== 8'h01) $display("[TB] FAIL alt_mode: got %0d expected 1", mode_o); else pass_cnt++;
      check_cnt++;
      if (mode_valid !== 1'b1) $display("[TB] FAIL alt_valid: got %0b expected 1", mode_valid); else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_silence;
      test_mode01;
      test_switch;
      test_timeout;
      test_glitch;
      test_reset_mid;
      test_alternate;
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
